// File: rtl/pic_ack_master_if.sv
`timescale 1ns/1ps
// Host-side request/response and vector-delivery bundle for pic_ack_master.
//
// Every valid/ready pair in this bundle transfers exactly one item on a cycle
// where valid and ready are both 1 at the rising clock edge. The producer holds
// valid and its payload stable until that edge, and must not wait for ready
// before raising valid. rsp_valid has no ready: it is a one-cycle pulse.
interface pic_ack_master_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_we;
   logic [1:0] req_sel;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       vec_valid;
   logic       vec_ready;
   logic [7:0] vec_data;
   logic       vec_err;

   // Host / vector consumer side.
   modport master (
      output req_valid, req_we, req_sel, req_wdata, vec_ready,
      input  req_ready, rsp_valid, rsp_rdata, vec_valid, vec_data, vec_err
   );

   // pic_ack_master side.
   modport slave (
      input  req_valid, req_we, req_sel, req_wdata, vec_ready,
      output req_ready, rsp_valid, rsp_rdata, vec_valid, vec_data, vec_err
   );
endinterface

// File: rtl/pic_ack_master.sv
`timescale 1ns/1ps
// CPU-side bus master for the PIC. Runs the two-pulse intackN acknowledge when
// the PIC raises its interrupt and captures the vector it returns, and
// otherwise carries host register reads/writes onto the shared PIC bus, so
// the interrupt path and the host never drive the bus together.
module pic_ack_master #(
   parameter int         ACK_W   = 2,        // cycles intackN low per pulse (>=2)
   parameter int         GAP_W   = 2,        // cycles intackN high between pulses (>=1)
   parameter int         COOL_W  = 2,        // idle cycles before pic_int is looked at again
   parameter logic [4:0] VEC_TAG = 5'b10100  // upper five bits of a well-formed vector
) (
   input  logic             clk,
   input  logic             resetN,
   inout  wire  [7:0]       pic_data,
   output logic [1:0]       pic_select,
   output logic             pic_readwrite,
   output logic             pic_intackN,
   input  logic             pic_int,
   pic_ack_master_if.slave  host,
   output logic [2:0]       dbg_state
);

   // Register select codes and bus direction as the PIC decodes them.
   localparam logic [1:0] SEL_OCR  = 2'd0;
   localparam logic       RW_WRITE = 1'b0;
   localparam logic       RW_READ  = 1'b1;

   // Phase lengths in counter units. The counter starts at 1 on entry to a
   // phase, so the phase lasts exactly N cycles when it leaves at cnt >= N.
   localparam logic [7:0] ACK_N  = 8'(ACK_W);
   localparam logic [7:0] GAP_N  = 8'(GAP_W);
   localparam logic [7:0] COOL_N = 8'(COOL_W);
   localparam logic [7:0] RD_N   = 8'd2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_RD   = 3'd2,
      S_ACK1 = 3'd3,
      S_GAP  = 3'd4,
      S_ACK2 = 3'd5,
      S_HOLD = 3'd6,
      S_COOL = 3'd7
   } state_t;

   state_t     state;
   logic [7:0] cnt;
   logic [7:0] wdata_q;
   logic       drive_en;

   // Saturating increment: a phase counter parks at 255 rather than wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // The data bus is only ever driven by this block while a write is on it.
   assign pic_data  = drive_en ? wdata_q : 8'hzz;

   assign dbg_state = state;

   // Sequencer: state, phase counter and every registered output.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state          <= S_IDLE;
         cnt            <= 8'd0;
         drive_en       <= 1'b0;
         pic_intackN    <= 1'b1;
         pic_readwrite  <= RW_READ;
         pic_select     <= SEL_OCR;
         host.req_ready <= 1'b0;
         host.rsp_valid <= 1'b0;
         host.rsp_rdata <= 8'h00;
         host.vec_valid <= 1'b0;
         host.vec_data  <= 8'h00;
         host.vec_err   <= 1'b0;
      end else begin
         // Both strobes are single-cycle; the states below re-raise them.
         host.req_ready <= 1'b0;
         host.rsp_valid <= 1'b0;

         case (state)
            S_IDLE: begin
               if (pic_int) begin
                  // Interrupt beats a simultaneous host request; the request
                  // simply stays pending until the sequence is over.
                  state       <= S_ACK1;
                  cnt         <= 8'd1;
                  pic_intackN <= 1'b0;
               end else if (host.req_valid) begin
                  host.req_ready <= 1'b1;
                  pic_select     <= host.req_sel;
                  wdata_q        <= host.req_wdata;
                  cnt            <= 8'd1;
                  if (host.req_we) begin
                     state         <= S_WR;
                     pic_readwrite <= RW_WRITE;
                     drive_en      <= 1'b1;
                  end else begin
                     state         <= S_RD;
                     pic_readwrite <= RW_READ;
                  end
               end
            end

            S_WR: begin
               // One write cycle on the bus, then release it.
               state         <= S_IDLE;
               drive_en      <= 1'b0;
               pic_readwrite <= RW_READ;
               pic_select    <= SEL_OCR;
            end

            S_RD: begin
               // The PIC gets two cycles to settle; take the data at the end.
               if (cnt >= RD_N) begin
                  host.rsp_rdata <= pic_data;
                  host.rsp_valid <= 1'b1;
                  pic_select     <= SEL_OCR;
                  state          <= S_IDLE;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end

            S_ACK1: begin
               if (cnt >= ACK_N) begin
                  state       <= S_GAP;
                  cnt         <= 8'd1;
                  pic_intackN <= 1'b1;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end

            S_GAP: begin
               if (cnt >= GAP_N) begin
                  state       <= S_ACK2;
                  cnt         <= 8'd1;
                  pic_intackN <= 1'b0;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end

            S_ACK2: begin
               // The vector is on the bus during the second pulse; sample it
               // on the last low cycle, when the PIC has had longest to drive.
               if (cnt >= ACK_N) begin
                  host.vec_data  <= pic_data;
                  host.vec_err   <= (pic_data[7:3] != VEC_TAG);
                  host.vec_valid <= 1'b1;
                  pic_intackN    <= 1'b1;
                  state          <= S_HOLD;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end

            S_HOLD: begin
               if (host.vec_ready) begin
                  host.vec_valid <= 1'b0;
                  cnt            <= 8'd1;
                  state          <= S_COOL;
               end
            end

            S_COOL: begin
               // pic_int is deliberately ignored here so the PIC can drop it.
               if (cnt >= COOL_N) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end

            default: begin
               state       <= S_IDLE;
               drive_en    <= 1'b0;
               pic_intackN <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pic_ack_master.sv
`timescale 1ns/1ps
// Bench for pic_ack_master: a small PIC model on the bus side, a cycle table
// for the back-to-back acknowledge sequences, hand-written write/read,
// collision and reset-abort sequences, then randomized traffic checked
// against a register/vector reference model.
module tb_pic_ack_master;

   localparam int         ACK_W   = 2;
   localparam int         GAP_W   = 2;
   localparam int         COOL_W  = 2;
   localparam logic [4:0] VEC_TAG = 5'b10100;

   localparam logic [1:0] SEL_OCR = 2'd0;
   localparam logic [1:0] SEL_IMR = 2'd1;
   localparam logic [1:0] SEL_IRR = 2'd2;
   localparam logic [1:0] SEL_ISR = 2'd3;

   // ---------------- clock / reset ----------------
   logic       clk    = 1'b0;
   logic       resetN = 1'b0;
   wire  [7:0] pic_data;
   logic [1:0] pic_select;
   logic       pic_readwrite;
   logic       pic_intackN;
   logic       pic_int = 1'b0;
   logic [2:0] dbg_state;

   pic_ack_master_if bus();

   always #5 clk = ~clk;

   pic_ack_master #(
      .ACK_W(ACK_W), .GAP_W(GAP_W), .COOL_W(COOL_W), .VEC_TAG(VEC_TAG)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .pic_data     (pic_data),
      .pic_select   (pic_select),
      .pic_readwrite(pic_readwrite),
      .pic_intackN  (pic_intackN),
      .pic_int      (pic_int),
      .host         (bus),
      .dbg_state    (dbg_state)
   );

   // ---------------- PIC model ----------------
   // Register file (reset values OCR=00 IMR=FF IRR=08 ISR=00), stores bus
   // writes; drives the bus whenever readwrite=1. Pulse 1 of the acknowledge
   // shows junk (EE), pulse 2 shows the vector.
   logic [7:0] pic_regs [4];
   logic [7:0] pic_vec = 8'hA3;
   logic [7:0] pic_out;
   int         pulse_no = 0;

   always @(posedge clk) begin
      if (!resetN) begin
         pic_regs[0] <= 8'h00;
         pic_regs[1] <= 8'hFF;
         pic_regs[2] <= 8'h08;
         pic_regs[3] <= 8'h00;
      end else if (!pic_readwrite) begin
         pic_regs[pic_select] <= pic_data;
      end
   end

   always @(negedge pic_intackN or negedge resetN) begin
      if (!resetN) pulse_no <= 0;
      else         pulse_no <= (pulse_no >= 2) ? 1 : pulse_no + 1;
   end

   always_comb begin
      pic_out = pic_regs[pic_select];
      if (!pic_intackN) pic_out = (pulse_no == 2) ? pic_vec : 8'hEE;
   end

   assign pic_data = pic_readwrite ? pic_out : 8'hzz;

   // ---------------- scoreboard ----------------
   int         n_vec = 0;
   int         n_err = 0;
   logic [8:0] exp_q[$];
   bit         saw_ready = 1'b0;
   logic [7:0] model_regs [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic host_write(input logic [1:0] sel, input logic [7:0] data, input int exp_wait);
      int  n;
      bit  got;
      got = 1'b0;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_sel = sel; bus.req_wdata = data;
      for (n = 0; n < 64; n++) begin
         tick();
         if (bus.req_ready) begin got = 1'b1; break; end
      end
      check("wr_accept", {got, n[7:0]}, {1'b1, exp_wait[7:0]});
      if (got) check("wr_bus", {pic_readwrite, pic_select, pic_data}, {1'b0, sel, data});
      bus.req_valid = 1'b0; bus.req_we = 1'b0;
      tick();
      check("wr_release", pic_readwrite, 1'b1);
   endtask

   task automatic host_read(input logic [1:0] sel, output logic [7:0] data);
      int n;
      bit got;
      got = 1'b0;
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_sel = sel;
      for (n = 0; n < 64; n++) begin
         tick();
         if (bus.req_ready) begin got = 1'b1; break; end
      end
      check("rd_accept", {got, n[7:0], pic_readwrite, pic_select}, {1'b1, 8'd0, 1'b1, sel});
      bus.req_valid = 1'b0;
      got = 1'b0;
      for (n = 1; n <= 16; n++) begin
         tick();
         if (bus.rsp_valid) begin got = 1'b1; break; end
      end
      check("rd_latency", {got, n[7:0]}, {1'b1, 8'd2});
      data = bus.rsp_rdata;
      tick();
      check("rsp_pulse", {bus.rsp_valid, bus.rsp_rdata}, {1'b0, data});
   endtask

   // One interrupt from assertion to the DUT being idle again.
   task automatic run_irq(input logic [7:0] vec, input int hold);
      logic [31:0] bits, eb;
      int          len, el;
      bit          got;
      logic [8:0]  e;
      bits = 0; eb = 0; len = 0; el = 0; got = 1'b0;
      for (int i = 0; i < ACK_W; i++) begin eb = {eb[30:0], 1'b0}; el++; end
      for (int i = 0; i < GAP_W; i++) begin eb = {eb[30:0], 1'b1}; el++; end
      for (int i = 0; i < ACK_W; i++) begin eb = {eb[30:0], 1'b0}; el++; end
      exp_q.push_back({(vec[7:3] != VEC_TAG), vec});
      pic_vec = vec;
      pic_int = 1'b1;
      for (int n = 0; n < 64; n++) begin
         tick();
         if (bus.req_ready) saw_ready = 1'b1;
         if (bus.vec_valid) begin got = 1'b1; break; end
         bits = {bits[30:0], pic_intackN};
         len++;
         if (!pic_intackN) pic_int = 1'b0;
      end
      pic_int = 1'b0;
      check("irq_vec_seen", got, 1'b1);
      check("ack_wave", {len[7:0], bits[23:0]}, {el[7:0], eb[23:0]});
      e = exp_q.pop_front();
      check("vec_capture", {bus.vec_err, bus.vec_data, pic_intackN}, {e, 1'b1});
      for (int h = 0; h < hold; h++) begin
         tick();
         if (bus.req_ready) saw_ready = 1'b1;
         check("vec_hold", {bus.vec_valid, bus.vec_err, bus.vec_data}, {1'b1, e});
      end
      bus.vec_ready = 1'b1;
      tick();
      check("vec_drop", bus.vec_valid, 1'b0);
      bus.vec_ready = 1'b0;
      for (int c = 0; c < COOL_W; c++) begin
         tick();
         if (bus.req_ready) saw_ready = 1'b1;
      end
   endtask

   // ---------------- cycle table ----------------
   typedef struct {
      logic       pic_int;
      logic       vec_ready;
      logic [7:0] vec;
      logic       exp_ack_n;
      logic       exp_vv;
      logic [7:0] exp_data;
      logic       exp_err;
   } row_t;

   row_t tbl [26];

   task automatic set_row(input int i, input logic irq, input logic rdy, input logic [7:0] v,
                          input logic ack_n, input logic vv, input logic [7:0] d, input logic err);
      tbl[i].pic_int = irq;    tbl[i].vec_ready = rdy; tbl[i].vec = v;
      tbl[i].exp_ack_n = ack_n; tbl[i].exp_vv = vv;    tbl[i].exp_data = d; tbl[i].exp_err = err;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd;
      logic [8:0] e;
      bit         bad;
      int         op;
      logic [1:0] sel;
      logic [7:0] data;
      logic [7:0] vec;

      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_sel = 2'd0; bus.req_wdata = 8'h00;
      bus.vec_ready = 1'b0;

      // IRQ with good tag, 5-cycle stall, then a back-to-back bad-tag IRQ
      // whose pic_int is already high during the cool-down.
      set_row(0, 1, 0, 8'hA3, 0, 0, 8'h00, 0);
      set_row(1, 1, 0, 8'hA3, 0, 0, 8'h00, 0);
      set_row(2, 1, 0, 8'hA3, 1, 0, 8'h00, 0);
      set_row(3, 0, 0, 8'hA3, 1, 0, 8'h00, 0);
      set_row(4, 0, 0, 8'hA3, 0, 0, 8'h00, 0);
      set_row(5, 0, 0, 8'hA3, 0, 0, 8'h00, 0);
      for (int i = 6; i <= 11; i++) set_row(i, 0, 0, 8'hA3, 1, 1, 8'hA3, 0);
      set_row(12, 0, 1, 8'hA3, 1, 0, 8'h00, 0);
      set_row(13, 1, 0, 8'h13, 1, 0, 8'h00, 0);
      set_row(14, 1, 0, 8'h13, 1, 0, 8'h00, 0);
      set_row(15, 1, 0, 8'h13, 0, 0, 8'h00, 0);
      set_row(16, 1, 0, 8'h13, 0, 0, 8'h00, 0);
      set_row(17, 0, 0, 8'h13, 1, 0, 8'h00, 0);
      set_row(18, 0, 0, 8'h13, 1, 0, 8'h00, 0);
      set_row(19, 0, 0, 8'h13, 0, 0, 8'h00, 0);
      set_row(20, 0, 0, 8'h13, 0, 0, 8'h00, 0);
      set_row(21, 0, 0, 8'h13, 1, 1, 8'h13, 1);
      set_row(22, 0, 1, 8'h13, 1, 0, 8'h00, 0);
      for (int i = 23; i <= 25; i++) set_row(i, 0, 0, 8'h13, 1, 0, 8'h00, 0);

      // Reset held for three cycles.
      repeat (3) tick();
      check("rst_intackN",   pic_intackN,   1'b1);
      check("rst_readwrite", pic_readwrite, 1'b1);
      check("rst_select",    pic_select,    2'd0);
      check("rst_strobes",   {bus.req_ready, bus.rsp_valid, bus.vec_valid}, 3'b000);
      check("rst_data_regs", {bus.rsp_rdata, bus.vec_data, bus.vec_err}, 17'd0);
      check("rst_bus",       pic_data,      8'h00);
      resetN = 1'b1;
      tick();

      for (int i = 0; i < 26; i++) begin
         pic_int = tbl[i].pic_int; bus.vec_ready = tbl[i].vec_ready; pic_vec = tbl[i].vec;
         tick();
         check($sformatf("table_row%0d", i),
               {pic_intackN, bus.vec_valid,
                tbl[i].exp_vv ? bus.vec_data : 8'h00, tbl[i].exp_vv ? bus.vec_err : 1'b0},
               {tbl[i].exp_ack_n, tbl[i].exp_vv, tbl[i].exp_data, tbl[i].exp_err});
      end
      pic_int = 1'b0; bus.vec_ready = 1'b0;

      // Write IMR, check the bus is released afterwards, then reads.
      host_write(SEL_IMR, 8'h5A, 0);
      tick();
      check("bus_released", pic_data, 8'h00);
      host_read(SEL_IRR, rd);
      check("read_irr", rd, 8'h08);
      host_read(SEL_IMR, rd);
      check("read_imr_after_write", rd, 8'h5A);

      // Request and interrupt in the same cycle: ack first, request stalls.
      saw_ready = 1'b0;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_sel = SEL_ISR; bus.req_wdata = 8'h3C;
      run_irq(8'hA5, 2);
      check("collision_stall", saw_ready, 1'b0);
      host_write(SEL_ISR, 8'h3C, 0);

      // Reset during GAP aborts the sequence with no vector.
      pic_int = 1'b1;
      tick(); tick(); tick();
      pic_int = 1'b0;
      resetN = 1'b0;
      tick();
      check("rst_gap", {pic_intackN, bus.vec_valid}, 2'b10);
      tick();
      resetN = 1'b1;
      bad = 1'b0;
      repeat (8) begin
         tick();
         if (!pic_intackN || bus.vec_valid) bad = 1'b1;
      end
      check("rst_abort", bad, 1'b0);
      check("rst_bus_release", pic_data, 8'h00);

      // Randomized traffic against the register/vector reference model.
      model_regs[0] = 8'h00; model_regs[1] = 8'hFF; model_regs[2] = 8'h08; model_regs[3] = 8'h00;
      for (int k = 0; k < 40; k++) begin
         op   = int'($urandom_range(0, 2));
         sel  = 2'($urandom_range(0, 3));
         data = 8'($urandom_range(0, 255));
         case (op)
            0: begin
               host_write(sel, data, 0);
               model_regs[sel] = data;
            end
            1: begin
               exp_q.push_back({1'b0, model_regs[sel]});
               host_read(sel, rd);
               e = exp_q.pop_front();
               check("rand_read", {1'b0, rd}, e);
            end
            default: begin
               vec = ($urandom_range(0, 1) == 1) ? {VEC_TAG, 3'($urandom_range(0, 7))} : data;
               run_irq(vec, int'($urandom_range(0, 3)));
            end
         endcase
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
